// File: rtl/board_refill_if.sv
// board_refill_if: handshake and data bundle between the elimination stage
// (master) and the refill stage (slave).
//   start        master->slave  single-cycle request, board_in sampled with it
//   board_in     master->slave  192-bit board, cell (x,y) at [(8x+y)*3 +: 3]
//   board_out    slave->master  working board, valid while busy=0
//   busy         slave->master  high while a board is being processed
//   generated    slave->master  one-cycle pulse, board_out complete and gap-free
//   refill_count slave->master  cells filled during the last run (0..64)
interface board_refill_if;
  logic         start;
  logic [191:0] board_in;
  logic [191:0] board_out;
  logic         busy;
  logic         generated;
  logic [6:0]   refill_count;

  modport master (
    output start, board_in,
    input  board_out, busy, generated, refill_count
  );

  modport slave (
    input  start, board_in,
    output board_out, busy, generated, refill_count
  );
endinterface

// File: rtl/board_refill.sv
// board_refill: takes a board with eliminated cells cleared to 0, lets the
// surviving cells fall down their column one gap per cycle, then fills every
// empty cell row-major with a colour drawn from a 16-bit LFSR and pulses
// generated. An all-zero input performs the initial board generation.
//
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-high reset
//   bus  board_refill_if.slave (start, board_in, board_out, busy,
//        generated, refill_count)
//
// Parameters: COLORS (3..7) fill colours 1..COLORS; SEED non-zero LFSR reset.
//
// Build option BOARD_REFILL_NO_ADJ_EN: a filled colour is bumped (at most
// twice) so it never equals its final left or upper neighbour. Timing and
// LFSR consumption are the same in both builds.
//
// state | meaning
// IDLE  | waiting for start
// FALL  | one gravity step per cycle until no column has a gap
// FILL  | scan cell idx (0..63), fill it if empty
// DONE  | generated=1 for one cycle
module board_refill #(
  parameter int          COLORS = 5,
  parameter logic [15:0] SEED   = 16'hACE1
) (
  input  logic          clk,
  input  logic          rst,
  board_refill_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FALL = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t       state_q;
  state_t       state_d;
  logic [191:0] board_q;
  logic [191:0] fall_board;
  logic [191:0] fill_board;
  logic [15:0]  lfsr_q;
  logic [15:0]  lfsr_next;
  logic [5:0]   idx_q;
  logic [6:0]   refill_q;
  logic         any_gap;
  logic [8:0]   fill_base;
  logic [2:0]   cur_cell;
  logic [2:0]   raw_colour;
  logic [2:0]   fill_colour;
  logic         busy_o;
  logic         gen_o;

  // x^16+x^14+x^13+x^11+1, shifting left with feedback into bit 0
  assign lfsr_next  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign raw_colour = 3'((int'(lfsr_q[2:0]) % COLORS) + 1);

  // cell index i = 8x+y, so the bit offset is simply 3*i
  assign fill_base = 9'(idx_q) * 9'd3;
  assign cur_cell  = board_q[fill_base +: 3];

  // One gravity step: in each column, the lowest gap swallows the cell above
  // it and everything above shifts down one row.
  always_comb begin : fall_step
    logic seen;
    logic col_gap;
    int   k;
    fall_board = board_q;
    any_gap    = 1'b0;
    seen       = 1'b0;
    col_gap    = 1'b0;
    k          = 0;
    for (int c = 0; c < 8; c++) begin
      seen    = 1'b0;
      col_gap = 1'b0;
      k       = 0;
      for (int r = 0; r < 8; r++) begin
        if (board_q[(8*r+c)*3 +: 3] == 3'd0) begin
          if (seen) begin
            col_gap = 1'b1;
            k       = r;
          end
        end else begin
          seen = 1'b1;
        end
      end
      if (col_gap) begin
        any_gap = 1'b1;
        fall_board[c*3 +: 3] = 3'd0;
        for (int r = 1; r < 8; r++) begin
          if (r <= k) begin
            fall_board[(8*r+c)*3 +: 3] = board_q[(8*(r-1)+c)*3 +: 3];
          end
        end
      end
    end
  end

`ifdef BOARD_REFILL_NO_ADJ_EN
  logic [8:0] left_base;
  logic [8:0] up_base;
  logic [2:0] left_cell;
  logic [2:0] up_cell;

  // Neighbours outside the board read as 0, which never matches a colour.
  assign left_base = (idx_q[2:0] != 3'd0) ? fill_base - 9'd3  : 9'd0;
  assign up_base   = (idx_q[5:3] != 3'd0) ? fill_base - 9'd24 : 9'd0;
  assign left_cell = (idx_q[2:0] != 3'd0) ? board_q[left_base +: 3] : 3'd0;
  assign up_cell   = (idx_q[5:3] != 3'd0) ? board_q[up_base +: 3]   : 3'd0;

  // Two bumps suffice: only two neighbours can be matched, COLORS >= 3.
  always_comb begin
    fill_colour = raw_colour;
    for (int n = 0; n < 2; n++) begin
      if (fill_colour == left_cell || fill_colour == up_cell) begin
        fill_colour = 3'((int'(fill_colour) % COLORS) + 1);
      end
    end
  end
`else
  assign fill_colour = raw_colour;
`endif

  always_comb begin
    fill_board = board_q;
    fill_board[fill_base +: 3] = fill_colour;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.start) state_d = FALL;
      FALL: if (!any_gap) state_d = FILL;
      FILL: if (idx_q == 6'd63) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o = 1'b0;
    gen_o  = 1'b0;
    case (state_q)
      FALL, FILL: busy_o = 1'b1;
      DONE:       gen_o  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      board_q  <= '0;
      lfsr_q   <= SEED;
      idx_q    <= '0;
      refill_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            board_q  <= bus.board_in;
            refill_q <= '0;
            idx_q    <= '0;
          end
        end
        FALL: begin
          board_q <= fall_board;
          idx_q   <= '0;
        end
        FILL: begin
          idx_q <= idx_q + 6'd1;
          if (cur_cell == 3'd0) begin
            board_q  <= fill_board;
            lfsr_q   <= lfsr_next;
            refill_q <= refill_q + 7'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.board_out    = board_q;
  assign bus.busy         = busy_o;
  assign bus.generated    = gen_o;
  assign bus.refill_count = refill_q;

endmodule

// File: tb/tb_board_refill.sv
// Self-checking bench for board_refill: directed boards plus random boards,
// compared against a column-queue gravity model and a software LFSR.
module tb_board_refill;
  localparam int          COLORS = 5;
  localparam logic [15:0] SEED   = 16'hACE1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  board_refill_if bus();

  board_refill #(.COLORS(COLORS), .SEED(SEED)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] m_lfsr = SEED;

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic int cell_of(input logic [191:0] b, input int x, input int y);
    return int'(b[(8*x+y)*3 +: 3]);
  endfunction

  // Reference: collect survivors per column, stack them at the bottom,
  // then fill row-major from the model LFSR.
  task automatic model_run(input logic [191:0] b_in, output logic [191:0] b_out,
                           output int cnt, output int g);
    int cells[8][8];
    for (int x = 0; x < 8; x++)
      for (int y = 0; y < 8; y++)
        cells[x][y] = cell_of(b_in, x, y);
    g = 0;
    for (int y = 0; y < 8; y++) begin
      int q[$];
      int zeros;
      bit seen;
      zeros = 0;
      seen  = 0;
      for (int x = 0; x < 8; x++) begin
        if (cells[x][y] != 0) begin
          seen = 1;
          q.push_back(cells[x][y]);
        end else if (seen) begin
          zeros++;
        end
      end
      if (zeros > g) g = zeros;
      for (int x = 0; x < 8; x++)
        cells[x][y] = (x < 8 - q.size()) ? 0 : q[x - (8 - q.size())];
    end
    cnt = 0;
    for (int x = 0; x < 8; x++) begin
      for (int y = 0; y < 8; y++) begin
        if (cells[x][y] == 0) begin
          int c;
          c = (int'(m_lfsr[2:0]) % COLORS) + 1;
`ifdef BOARD_REFILL_NO_ADJ_EN
          for (int n = 0; n < 2; n++)
            if ((y > 0 && c == cells[x][y-1]) || (x > 0 && c == cells[x-1][y]))
              c = (c % COLORS) + 1;
`endif
          cells[x][y] = c;
          m_lfsr = lfsr_step(m_lfsr);
          cnt++;
        end
      end
    end
    b_out = '0;
    for (int x = 0; x < 8; x++)
      for (int y = 0; y < 8; y++)
        b_out[(8*x+y)*3 +: 3] = 3'(cells[x][y]);
  endtask

  task automatic run(input string tag, input logic [191:0] b, input int inject,
                     input logic [191:0] b2, output logic [191:0] res);
    logic [191:0] exp_b;
    int exp_cnt, g, gen_n, gen_count;
    bit busy_bad;
    model_run(b, exp_b, exp_cnt, g);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.board_in = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    gen_n     = -1;
    gen_count = 0;
    busy_bad  = 0;
    for (int n = 1; n <= 100; n++) begin
      if (n == inject) begin
        bus.start    = 1'b1;
        bus.board_in = b2;
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      if (bus.generated) begin
        gen_count++;
        if (gen_n < 0) gen_n = n;
      end
      if (bus.busy !== (n < 65 + g)) busy_bad = 1;
    end
    check({tag, "_latency"}, 192'(gen_n), 192'(65 + g));
    check({tag, "_pulses"}, 192'(gen_count), 192'd1);
    check({tag, "_busy"}, 192'(busy_bad), 192'd0);
    check({tag, "_board"}, bus.board_out, exp_b);
    check({tag, "_count"}, 192'(bus.refill_count), 192'(exp_cnt));
    res = bus.board_out;
  endtask

  function automatic logic [191:0] rand_board();
    logic [191:0] b;
    b = '0;
    for (int i = 0; i < 64; i++)
      b[i*3 +: 3] = ($urandom_range(0, 2) == 0) ? 3'd0 : 3'($urandom_range(1, COLORS));
    return b;
  endfunction

  initial begin
    logic [191:0] b, b2, res, init_res, res2;
    bit bad;
    bus.start    = 1'b0;
    bus.board_in = '0;

    // asynchronous reset between edges
    #2 rst = 1'b1;
    #1;
    check("rst_board", bus.board_out, '0);
    check("rst_busy", 192'(bus.busy), 192'd0);
    check("rst_gen", 192'(bus.generated), 192'd0);
    check("rst_count", 192'(bus.refill_count), 192'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk);
      #1;
      if (bus.board_out !== '0 || bus.busy !== 1'b0 || bus.generated !== 1'b0 ||
          bus.refill_count !== 7'd0) bad = 1;
    end
    check("idle_hold", 192'(bad), 192'd0);

    // initial generation from an all-zero board
    run("init", '0, 0, '0, init_res);
    check("init_count64", 192'(bus.refill_count), 192'd64);
    bad = 0;
    for (int i = 0; i < 64; i++)
      if (init_res[i*3 +: 3] < 3'd1 || int'(init_res[i*3 +: 3]) > COLORS) bad = 1;
    check("init_range", 192'(bad), 192'd0);
`ifdef BOARD_REFILL_NO_ADJ_EN
    bad = 0;
    for (int x = 0; x < 8; x++)
      for (int y = 0; y < 8; y++) begin
        if (y > 0 && cell_of(init_res, x, y) == cell_of(init_res, x, y-1)) bad = 1;
        if (x > 0 && cell_of(init_res, x, y) == cell_of(init_res, x-1, y)) bad = 1;
      end
    check("init_no_adj", 192'(bad), 192'd0);
`endif

    // single gap at (5,3) in a board of colour 2
    b = {64{3'd2}};
    b[(8*5+3)*3 +: 3] = 3'd0;
    run("gap1", b, 0, '0, res);
    check("gap1_count1", 192'(bus.refill_count), 192'd1);
    bad = 0;
    for (int x = 1; x <= 5; x++) if (cell_of(res, x, 3) != 2) bad = 1;
    check("gap1_col3", 192'(bad), 192'd0);

    // column 0 alternating 0,1 top to bottom, rest colour 3
    b = {64{3'd3}};
    for (int x = 0; x < 8; x++) b[(8*x)*3 +: 3] = (x % 2 == 0) ? 3'd0 : 3'd1;
    run("alt", b, 0, '0, res);
    check("alt_count4", 192'(bus.refill_count), 192'd4);
    bad = 0;
    for (int x = 4; x < 8; x++) if (cell_of(res, x, 0) != 1) bad = 1;
    check("alt_col0", 192'(bad), 192'd0);

    // second start while busy is ignored
    b  = rand_board();
    b2 = {64{3'd1}};
    run("busy_start", b, 10, b2, res);

    for (int t = 0; t < 4; t++) begin
      b = rand_board();
      run($sformatf("rand%0d", t), b, 0, '0, res);
    end

    // reset in the middle of FILL, then a fresh run must repeat init exactly
    @(negedge clk);
    bus.start    = 1'b1;
    bus.board_in = '0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int n = 0; n < 30; n++) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_board", bus.board_out, '0);
    check("mid_rst_busy", 192'(bus.busy), 192'd0);
    check("mid_rst_gen", 192'(bus.generated), 192'd0);
    check("mid_rst_count", 192'(bus.refill_count), 192'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int n = 0; n < 80; n++) begin
      @(posedge clk);
      #1;
      if (bus.generated !== 1'b0 || bus.busy !== 1'b0) bad = 1;
    end
    check("mid_rst_no_gen", 192'(bad), 192'd0);
    m_lfsr = SEED;
    run("rerun", '0, 0, '0, res2);
    check("rerun_eq_init", res2, init_res);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
